// File: rtl/toy_pkg.sv
// Shared definitions for the toy accumulator core: opcodes, FSM states, ALU codes, decode record.
// Latency: none (types and constants only).
// Backpressure: none.
package toy_pkg;

  // Default datapath geometry; the IR carries a 4-bit opcode above the address field
  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 16;
  localparam int OPC_W      = 4;

  // Instruction set
  localparam logic [OPC_W-1:0] OP_HALT  = 4'h0;
  localparam logic [OPC_W-1:0] OP_LDA   = 4'h1;
  localparam logic [OPC_W-1:0] OP_STA   = 4'h2;
  localparam logic [OPC_W-1:0] OP_ADD   = 4'h3;
  localparam logic [OPC_W-1:0] OP_SUB   = 4'h4;
  localparam logic [OPC_W-1:0] OP_AND   = 4'h5;
  localparam logic [OPC_W-1:0] OP_XOR   = 4'h6;
  localparam logic [OPC_W-1:0] OP_LDT   = 4'h7;
  localparam logic [OPC_W-1:0] OP_MOVAT = 4'h8;
  localparam logic [OPC_W-1:0] OP_JMP   = 4'h9;
  localparam logic [OPC_W-1:0] OP_JZ    = 4'hA;
  localparam logic [OPC_W-1:0] OP_JN    = 4'hB;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_MEM,
    ST_WB,
    ST_EXEC,
    ST_HALT
  } state_t;

  typedef enum logic [2:0] {
    ALU_PASS_MDR = 3'd0,
    ALU_ADD      = 3'd1,
    ALU_SUB      = 3'd2,
    ALU_AND      = 3'd3,
    ALU_XOR      = 3'd4,
    ALU_PASS_A   = 3'd5
  } alu_op_t;

  typedef enum logic [1:0] {
    CLS_HALT,
    CLS_MEM,
    CLS_EXEC
  } op_class_t;

  typedef enum logic [1:0] {
    JC_NEVER,
    JC_ALWAYS,
    JC_ZERO,
    JC_NEG
  } jcond_t;

  // Everything the sequencer needs to know about the instruction in IR
  typedef struct packed {
    op_class_t cls;
    logic      is_store;
    logic      a_dest;
    alu_op_t   alu_op;
    logic      t_dest;
    jcond_t    jcond;
  } dec_t;

  // Branch resolution against the accumulator flags
  function automatic logic jump_taken(input jcond_t jc, input logic zero, input logic neg);
    case (jc)
      JC_ALWAYS: return 1'b1;
      JC_ZERO:   return zero;
      JC_NEG:    return neg;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/toy_decode.sv
// Opcode decoder: maps IR[15:12] onto class, store flag, ALU function, destinations and jump condition.
// Latency: purely combinational.
// Backpressure: none.
module toy_decode
  import toy_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  output dec_t             dec
);

  // Instruction table; unlisted opcodes (C-F) behave as EXEC-class no-ops
  always_comb begin
    dec.cls      = CLS_EXEC;
    dec.is_store = 1'b0;
    dec.a_dest   = 1'b0;
    dec.alu_op   = ALU_PASS_MDR;
    dec.t_dest   = 1'b0;
    dec.jcond    = JC_NEVER;
    case (opcode)
      OP_HALT: dec.cls = CLS_HALT;
      OP_LDA: begin
        dec.cls    = CLS_MEM;
        dec.a_dest = 1'b1;
        dec.alu_op = ALU_PASS_MDR;
      end
      OP_STA: begin
        dec.cls      = CLS_MEM;
        dec.is_store = 1'b1;
      end
      OP_ADD: begin
        dec.cls    = CLS_MEM;
        dec.a_dest = 1'b1;
        dec.alu_op = ALU_ADD;
      end
      OP_SUB: begin
        dec.cls    = CLS_MEM;
        dec.a_dest = 1'b1;
        dec.alu_op = ALU_SUB;
      end
      OP_AND: begin
        dec.cls    = CLS_MEM;
        dec.a_dest = 1'b1;
        dec.alu_op = ALU_AND;
      end
      OP_XOR: begin
        dec.cls    = CLS_MEM;
        dec.a_dest = 1'b1;
        dec.alu_op = ALU_XOR;
      end
      OP_LDT: begin
        dec.cls    = CLS_MEM;
        dec.t_dest = 1'b1;
      end
      // T takes A through the ALU pass-through path
      OP_MOVAT: begin
        dec.t_dest = 1'b1;
        dec.alu_op = ALU_PASS_A;
      end
      OP_JMP:  dec.jcond = JC_ALWAYS;
      OP_JZ:   dec.jcond = JC_ZERO;
      OP_JN:   dec.jcond = JC_NEG;
      default: ;
    endcase
  end

endmodule

// File: rtl/toy_control.sv
// Sequencer for the toy accumulator core: fetch/decode/memory/writeback/exec with retirement counter.
// Latency: zero-wait memory ops 4 cycles (STA 3), EXEC ops 3 cycles; FETCH and MEM stretch per wait state.
// Backpressure: memory stalls by withholding mem_ack; request and address select are held until acked.
module toy_control
  import toy_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [OPC_W-1:0] opcode,
  input  logic             a_zero,
  input  logic             a_neg,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic             ir_load,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             mdr_load,
  output logic             a_load,
  output logic             t_load,
  output logic [2:0]       alu_op,
  output logic             halted,
  output logic [15:0]      retired
);

  // The IR word must hold the opcode field above the operand address
  if (DATA_W < ADDR_W + OPC_W) begin : g_width_check
    $error("toy_control: DATA_W too narrow for opcode plus ADDR_W address");
  end

  state_t      state_q, state_d;
  dec_t        dec, dec_q;
  logic        retire;
  logic [15:0] retired_q;

  toy_decode u_decode (
    .opcode (opcode),
    .dec    (dec)
  );

  // State register; reset lands in IDLE, which drives every output low
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Capture the decode in DECODE so later phases do not depend on IR staying put
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dec_q.cls      <= CLS_EXEC;
      dec_q.is_store <= 1'b0;
      dec_q.a_dest   <= 1'b0;
      dec_q.alu_op   <= ALU_PASS_MDR;
      dec_q.t_dest   <= 1'b0;
      dec_q.jcond    <= JC_NEVER;
    end else if (state_q == ST_DECODE) begin
      dec_q <= dec;
    end
  end

  // Retired-instruction counter; wraps naturally at 16 bits
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      retired_q <= '0;
    else if (retire) retired_q <= retired_q + 16'd1;
  end

  // Next-state and strobe generation; strobes are Moore except the ack-qualified ones
  always_comb begin
    state_d  = state_q;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    addr_sel = 1'b0;
    ir_load  = 1'b0;
    pc_inc   = 1'b0;
    pc_load  = 1'b0;
    mdr_load = 1'b0;
    a_load   = 1'b0;
    t_load   = 1'b0;
    alu_op   = ALU_PASS_MDR;
    retire   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_load = 1'b1;
          pc_inc  = 1'b1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        case (dec.cls)
          CLS_HALT: state_d = ST_HALT;
          CLS_MEM:  state_d = ST_MEM;
          default:  state_d = ST_EXEC;
        endcase
      end
      ST_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = dec_q.is_store;
        if (mem_ack) begin
          if (dec_q.is_store) begin
            retire  = 1'b1;
            state_d = ST_FETCH;
          end else begin
            mdr_load = 1'b1;
            state_d  = ST_WB;
          end
        end
      end
      ST_WB: begin
        a_load  = dec_q.a_dest;
        t_load  = dec_q.t_dest;
        alu_op  = dec_q.alu_op;
        retire  = 1'b1;
        state_d = ST_FETCH;
      end
      ST_EXEC: begin
        t_load  = dec_q.t_dest;
        if (dec_q.t_dest) alu_op = dec_q.alu_op;
        pc_load = jump_taken(dec_q.jcond, a_zero, a_neg);
        retire  = 1'b1;
        state_d = ST_FETCH;
      end
      ST_HALT: ;
      default: state_d = ST_IDLE;
    endcase
  end

  assign halted  = (state_q == ST_HALT);
  assign retired = retired_q;

endmodule

// File: tb/tb_toy_control.sv
// Bench for toy_control: directed programs plus randomized instruction stream with random wait states.
// Latency: expected cycle counts come from an instruction-level table.
// Backpressure: a responder inserts per-request wait states and spurious acks while idle.
module tb_toy_control;
  import toy_pkg::*;

  logic        clk = 1'b0;
  logic        reset, run, a_zero, a_neg, mem_ack;
  logic [3:0]  opcode;
  logic        mem_req, mem_we, addr_sel, ir_load, pc_inc, pc_load, mdr_load, a_load, t_load, halted;
  logic [2:0]  alu_op;
  logic [15:0] retired;

  int          tests = 0;
  int          fails = 0;
  logic [15:0] model_ret;

  always #5 clk = ~clk;

  toy_control #(.ADDR_W(12), .DATA_W(16)) dut (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode),
    .a_zero(a_zero), .a_neg(a_neg), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
    .ir_load(ir_load), .pc_inc(pc_inc), .pc_load(pc_load), .mdr_load(mdr_load),
    .a_load(a_load), .t_load(t_load), .alu_op(alu_op),
    .halted(halted), .retired(retired)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [12:0] all_outs();
    return {mem_req, mem_we, addr_sel, ir_load, pc_inc, pc_load, mdr_load,
            a_load, t_load, halted, alu_op};
  endfunction

  // Hold reset across an edge, check the reset state, release; ends at a negedge in IDLE
  task automatic do_reset();
    reset = 1'b0; run = 1'b0; mem_ack = 1'b0; opcode = 4'h0; a_zero = 1'b0; a_neg = 1'b0;
    @(negedge clk); #1;
    check("reset_outputs", all_outs(), 13'h0);
    check("reset_retired", retired, 16'h0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    model_ret = 16'h0;
  endtask

  // Raise run in IDLE; FETCH must begin on the following cycle
  task automatic start();
    run = 1'b1; #1;
    check("idle_no_req", mem_req, 1'b0);
    @(posedge clk); @(negedge clk);
    run = 1'b0; #1;
    check("first_fetch_req", mem_req, 1'b1);
  endtask

  // Execute one instruction from its FETCH cycle and compare strobe totals with the ISA table
  task automatic run_instr(input logic [3:0] op, input int fw, input int mw, input logic z, input logic n);
    bit   is_halt, is_mem, store;
    int   e_a, e_alu, e_t, e_mdr, e_pcl, e_cyc;
    int   c_ir, c_inc, c_pcl, c_mdr, c_a, c_t, c_we, c_req, bad, got_alu, req_cnt;
    logic p_wait, p_addr, p_we, s_req, s_ack, s_ir;
    is_halt = (op == 4'h0);
    is_mem  = (op >= 4'h1) && (op <= 4'h7);
    store   = (op == 4'h2);
    e_a = 0; e_alu = 0; e_t = 0; e_pcl = 0;
    case (op)
      4'h1: begin e_a = 1; e_alu = 0; end
      4'h3: begin e_a = 1; e_alu = 1; end
      4'h4: begin e_a = 1; e_alu = 2; end
      4'h5: begin e_a = 1; e_alu = 3; end
      4'h6: begin e_a = 1; e_alu = 4; end
      4'h7, 4'h8: e_t = 1;
      4'h9: e_pcl = 1;
      4'hA: e_pcl = int'(z);
      4'hB: e_pcl = int'(n);
      default: ;
    endcase
    e_mdr = (is_mem && !store) ? 1 : 0;
    e_cyc = fw + 2 + (is_halt ? 0 : (is_mem ? (mw + 1 + (store ? 0 : 1)) : 1));
    c_ir = 0; c_inc = 0; c_pcl = 0; c_mdr = 0; c_a = 0; c_t = 0; c_we = 0; c_req = 0;
    bad = 0; got_alu = -1; req_cnt = 0; p_wait = 1'b0; p_addr = 1'b0; p_we = 1'b0;
    a_zero = z; a_neg = n;
    for (int c = 0; c < e_cyc; c++) begin
      if (mem_req) mem_ack = (req_cnt == (addr_sel ? mw : fw));
      else         mem_ack = 1'($urandom_range(0, 1));
      #1;
      c_ir  += int'(ir_load);  c_inc += int'(pc_inc); c_pcl += int'(pc_load);
      c_mdr += int'(mdr_load); c_a   += int'(a_load); c_t   += int'(t_load);
      c_we  += int'(mem_we);   c_req += int'(mem_req);
      if (a_load) got_alu = int'(alu_op);
      if (pc_inc && pc_load) bad++;
      if (mem_we && !mem_req) bad++;
      if (p_wait && (mem_req !== 1'b1 || addr_sel !== p_addr || mem_we !== p_we)) bad++;
      p_wait = mem_req && !mem_ack; p_addr = addr_sel; p_we = mem_we;
      s_req = mem_req; s_ack = mem_ack; s_ir = ir_load;
      @(posedge clk);
      if (s_req && s_ack) req_cnt = 0;
      else if (s_req)     req_cnt++;
      @(negedge clk);
      if (s_ir) opcode = op;
    end
    check($sformatf("op%0h_ir_load", op), c_ir, 1);
    check($sformatf("op%0h_pc_inc", op), c_inc, 1);
    check($sformatf("op%0h_pc_load", op), c_pcl, e_pcl);
    check($sformatf("op%0h_mdr_load", op), c_mdr, e_mdr);
    check($sformatf("op%0h_a_load", op), c_a, e_a);
    if (e_a == 1) check($sformatf("op%0h_alu_op", op), got_alu, e_alu);
    check($sformatf("op%0h_t_load", op), c_t, e_t);
    check($sformatf("op%0h_we_cycles", op), c_we, store ? mw + 1 : 0);
    check($sformatf("op%0h_req_cycles", op), c_req, fw + 1 + (is_mem ? mw + 1 : 0));
    check($sformatf("op%0h_protocol", op), bad, 0);
    if (!is_halt) model_ret = model_ret + 16'd1;
    mem_ack = 1'b0; #1;
    if (is_halt) begin
      check("halt_flag", halted, 1'b1);
      check("halt_no_req", mem_req, 1'b0);
    end else begin
      check($sformatf("op%0h_next_fetch", op), {mem_req, addr_sel, halted}, 3'b100);
    end
    check($sformatf("op%0h_retired", op), retired, model_ret);
  endtask

  initial begin
    reset = 1'b0; run = 1'b0; mem_ack = 1'b0; opcode = 4'h0; a_zero = 1'b0; a_neg = 1'b0;
    model_ret = 16'h0;

    // Zero-wait program: LDA, ADD, STA, HALT
    do_reset();
    start();
    run_instr(OP_LDA, 0, 0, 1'b0, 1'b0);
    run_instr(OP_ADD, 0, 0, 1'b0, 1'b0);
    run_instr(OP_STA, 0, 0, 1'b0, 1'b0);
    run_instr(OP_HALT, 0, 0, 1'b0, 1'b0);
    check("program_retired", retired, 16'd3);

    // HALT ignores run and stray acks
    for (int i = 0; i < 8; i++) begin
      run = 1'($urandom_range(0, 1)); mem_ack = 1'($urandom_range(0, 1));
      @(posedge clk); @(negedge clk); #1;
      check("halt_hold", {halted, mem_req, ir_load, pc_inc}, 4'b1000);
    end

    // Delayed fetch ack, then conditional branches both ways
    do_reset();
    start();
    run_instr(4'hC, 3, 0, 1'b0, 1'b0);
    run_instr(OP_JZ, 0, 0, 1'b1, 1'b0);
    run_instr(OP_JZ, 0, 0, 1'b0, 1'b1);
    run_instr(OP_JN, 1, 0, 1'b0, 1'b1);
    run_instr(OP_JN, 0, 0, 1'b1, 1'b0);
    run_instr(OP_JMP, 0, 0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of an unacknowledged fetch
    check("pre_reset_req", mem_req, 1'b1);
    #1 reset = 1'b0;
    #1;
    check("mid_reset_req_drop", mem_req, 1'b0);
    check("mid_reset_retired", retired, 16'h0);
    check("mid_reset_outputs", all_outs(), 13'h0);
    @(negedge clk); reset = 1'b1;
    repeat (3) @(negedge clk);
    #1 check("idle_stays_idle", mem_req, 1'b0);
    @(negedge clk);

    // Randomized instruction stream with random wait states
    do_reset();
    start();
    for (int i = 0; i < 150; i++) begin
      run_instr(4'($urandom_range(1, 15)), $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    run_instr(OP_HALT, $urandom_range(0, 3), 0, 1'b0, 1'b0);

    // Counter wrap: preload near the top, then retire two NOPs
    do_reset();
    force dut.retired_q = 16'hFFFE;
    #1 release dut.retired_q;
    model_ret = 16'hFFFE;
    #1 check("preload_retired", retired, 16'hFFFE);
    @(negedge clk);
    start();
    run_instr(4'hF, 0, 0, 1'b0, 1'b0);
    run_instr(4'hD, 0, 0, 1'b0, 1'b0);
    check("wrap_to_zero", retired, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/toy_control.md
TOY_CONTROL -- requirements
Module: toy_control

Interface
REQ-001 Parameter ADDR_W, default 12, PC/operand address width.
REQ-002 Parameter DATA_W, default 16, instruction/data word width.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 run  input  1  start request; level, sampled in IDLE only.
REQ-006 opcode  input  4  IR[15:12] from datapath.
REQ-007 a_zero, a_neg  input  1 each  datapath flags: A==0, A[DATA_W-1].
REQ-008 mem_ack  input  1  memory completes the current request this cycle.
REQ-009 mem_req, mem_we  output  1 each  memory request, write qualifier.
REQ-010 addr_sel  output  1  0 = PC drives memory address, 1 = IR[ADDR_W-1:0].
REQ-011 ir_load, pc_inc, pc_load, mdr_load, a_load, t_load  output  1 each  datapath strobes, one-cycle pulses.
REQ-012 alu_op  output  3  ALU function for a_load: 0 PASS_MDR, 1 ADD, 2 SUB, 3 AND, 4 XOR, 5 PASS_A.
REQ-013 halted  output  1  core stopped on HALT.
REQ-014 retired  output  16  count of completed instructions.

Function
REQ-015 States: IDLE, FETCH, DECODE, MEM, WB, EXEC, HALT.
REQ-016 IDLE: all strobes 0; run=1 -> FETCH next cycle.
REQ-017 FETCH: mem_req=1, addr_sel=0, mem_we=0 every cycle until mem_ack; ack cycle pulses ir_load and pc_inc, -> DECODE.
REQ-018 DECODE: one cycle, no strobes; opcode 0 -> HALT; 1-7 -> MEM; 8-F -> EXEC.
REQ-019 Opcodes: 0 HALT, 1 LDA, 2 STA, 3 ADD, 4 SUB, 5 AND, 6 XOR, 7 LDT, 8 MOVAT (T<-A), 9 JMP, A JZ, B JN, C-F NOP.
REQ-020 MEM: mem_req=1, addr_sel=1, mem_we=1 only for STA, held until mem_ack; on ack STA -> FETCH (retires), others pulse mdr_load -> WB.
REQ-021 WB: one cycle; LDA/ADD/SUB/AND/XOR pulse a_load with alu_op 0/1/2/3/4; LDT pulses t_load; -> FETCH.
REQ-022 EXEC: one cycle; MOVAT pulses t_load; JMP pulses pc_load; JZ pulses pc_load iff a_zero; JN iff a_neg; NOP no strobe; -> FETCH.
REQ-023 HALT: halted=1, no strobes, no exit except reset; run ignored.
REQ-024 retired increments by 1 on the cycle leaving WB, EXEC, or MEM-for-STA; wraps 0xFFFF -> 0x0000; HALT not counted.
REQ-025 mem_req/addr_sel/mem_we stable while awaiting ack; mem_ack with mem_req=0 ignored.
REQ-026 mem_ack on the first request cycle is legal: zero wait states, FETCH lasts one cycle.
REQ-027 Strobes are Moore/Mealy-on-ack only; never two of pc_inc, pc_load in one cycle.
REQ-028 Instruction latency with zero-wait memory: memory ops 4 cycles (STA 3), EXEC ops 3 cycles.

Reset
REQ-029 reset low forces state IDLE, retired=0, all outputs 0 asynchronously, including mid-request (mem_req drops immediately).
REQ-030 Release of reset is synchronous to clk; first possible FETCH is the cycle after run sampled high.

Structure
REQ-031 toy_pkg holds opcode constants, state enum, alu_op encoding, ADDR_W/DATA_W defaults; shared with datapath and bench.
REQ-032 One combinational sub-module toy_decode: opcode -> class (halt/mem/exec), is_store, alu_op, t_dest, jump condition.

Verification
REQ-033 Reset low mid-FETCH with mem_req=1 -> mem_req=0 same cycle, state IDLE, retired=0.
REQ-034 Zero-wait program LDA 0x010, ADD 0x011, STA 0x012, HALT -> a_load pulses alu_op 0 then 1, mem_we=1 only in STA MEM, halted=1, retired=3.
REQ-035 FETCH with mem_ack delayed 3 cycles -> mem_req held 4 cycles, addr_sel=0 steady, single ir_load/pc_inc.
REQ-036 JZ with a_zero=1 -> pc_load pulse, no pc_inc in EXEC; with a_zero=0 -> no pc_load; JN likewise with a_neg.
REQ-037 retired preset to 0xFFFF via 65535 NOPs, one more NOP -> retired=0x0000.
REQ-038 HALT reached, run toggled -> halted stays 1, no mem_req until reset.
